// File: rtl/pipereg_skid_stage_pkg.sv
// Shared types and constants for the skid-buffered pipeline register.
// Callers can use PIPE_BUBBLE_PC when they build their BUBBLE_VAL payload.
package pipereg_skid_stage_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } pipereg_occ_t;

  localparam logic [63:0] PIPE_BUBBLE_PC = 64'h8000_0000;

endpackage

// File: rtl/pipereg_skid_stage_sat_counter.sv
// Saturating event counter that sticks at all-ones; clear is synchronous and wins over inc.
// The counter only exists when PIPEREG_PERF_EN is defined.
`ifdef PIPEREG_PERF_EN
module pipereg_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/pipereg_skid_stage.sv
// Pipeline register with valid/ready handshake and a 2-entry skid buffer (main + skid).
// Defining PIPEREG_PERF_EN adds the stall_cnt/bubble_cnt saturating performance counters.
module pipereg_skid_stage
  import pipereg_skid_stage_pkg::*;
#(
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int               CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
`ifdef PIPEREG_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  // Handshake: a transfer happens on a posedge where valid and ready are both high.
  // in_ready comes only from registered state, so out_ready never reaches in_ready combinationally.

  logic             m_vld_q, m_vld_d;
  logic [WIDTH-1:0] m_dat_q, m_dat_d;
  logic             s_vld_q, s_vld_d;
  logic [WIDTH-1:0] s_dat_q, s_dat_d;
  pipereg_occ_t     occ_state;
  logic             accept;
  logic             pop;

  always_comb begin
    case ({s_vld_q, m_vld_q})
      2'b00:   occ_state = OCC_EMPTY;
      2'b01:   occ_state = OCC_ONE;
      default: occ_state = OCC_TWO;
    endcase
  end

  assign in_ready  = ~s_vld_q;
  assign accept    = in_valid & in_ready;
  assign pop       = m_vld_q & out_ready;
  assign out_valid = m_vld_q;
  assign out_data  = m_vld_q ? m_dat_q : BUBBLE_VAL;
  assign occupancy = occ_state;

  always_comb begin
    m_vld_d = m_vld_q;
    m_dat_d = m_dat_q;
    s_vld_d = s_vld_q;
    s_dat_d = s_dat_q;
    case (occ_state)
      OCC_EMPTY: begin
        if (accept) begin
          m_vld_d = 1'b1;
          m_dat_d = in_data;
        end
      end
      OCC_ONE: begin
        if (pop && accept) begin
          m_dat_d = in_data;
        end else if (pop) begin
          m_vld_d = 1'b0;
          m_dat_d = BUBBLE_VAL;
        end else if (accept) begin
          s_vld_d = 1'b1;
          s_dat_d = in_data;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          m_dat_d = s_dat_q;
          s_vld_d = 1'b0;
          s_dat_d = BUBBLE_VAL;
        end
      end
      default: ;
    endcase
    // Flush squashes both held entries and anything accepted this cycle.
    if (flush) begin
      m_vld_d = 1'b0;
      m_dat_d = BUBBLE_VAL;
      s_vld_d = 1'b0;
      s_dat_d = BUBBLE_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_vld_q <= 1'b0;
      m_dat_q <= BUBBLE_VAL;
      s_vld_q <= 1'b0;
      s_dat_q <= BUBBLE_VAL;
    end else begin
      m_vld_q <= m_vld_d;
      m_dat_q <= m_dat_d;
      s_vld_q <= s_vld_d;
      s_dat_q <= s_dat_d;
    end
  end

`ifdef PIPEREG_PERF_EN
  pipereg_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (m_vld_q & ~out_ready),
    .count (stall_cnt)
  );

  pipereg_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (~m_vld_q & out_ready),
    .count (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipereg_skid_stage.sv
// Self-checking bench for pipereg_skid_stage against a queue-based reference model.
// Counter checks are compiled in when PIPEREG_PERF_EN is defined.
module tb_pipereg_skid_stage;

  localparam int          WIDTH  = 64;
  localparam logic [63:0] BUBBLE = 64'h8000_0000;
  localparam int          CNT_W  = 4;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
`ifdef PIPEREG_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFO of held payloads (capacity 2) and saturating counters.
  logic [WIDTH-1:0] exp_q[$];
  int               exp_stall  = 0;
  int               exp_bubble = 0;

  pipereg_skid_stage #(
    .WIDTH      (WIDTH),
    .BUBBLE_VAL (BUBBLE),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPEREG_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    int sz;
    sz = exp_q.size();
    check("out_valid", 64'(out_valid), 64'(sz > 0));
    check("out_data", out_data, (sz > 0) ? exp_q[0] : BUBBLE);
    check("in_ready", 64'(in_ready), 64'(sz < 2));
    check("occupancy", 64'(occupancy), 64'(sz));
`ifdef PIPEREG_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    check("bubble_cnt", 64'(bubble_cnt), 64'(exp_bubble));
`endif
  endtask

  // Drive one cycle's inputs (called at negedge), advance the model at posedge,
  // then compare all outputs on the following negedge.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [WIDTH-1:0] d, input logic ordy);
    int sz;
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      exp_stall  = 0;
      exp_bubble = 0;
    end else begin
      if (sz > 0 && !ordy && exp_stall < CMAX) exp_stall++;
      if (sz == 0 && ordy && exp_bubble < CMAX) exp_bubble++;
      if (fl) begin
        exp_q.delete();
      end else begin
        if (sz > 0 && ordy) void'(exp_q.pop_front());
        if (iv && sz < 2) exp_q.push_back(d);
      end
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);

    // 1: reset for 3 cycles
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0, 0);
    check("t1_out_valid", 64'(out_valid), 64'd0);
    check("t1_out_data", out_data, 64'h8000_0000);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    check("t1_occupancy", 64'(occupancy), 64'd0);

    // 2: stream 1..8 with out_ready held high, 1-cycle latency
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 1, 64'(i), 1);
      check("t2_stream_data", out_data, 64'(i));
      check("t2_stream_ready", 64'(in_ready), 64'd1);
    end
    cycle(0, 0, 0, '0, 1);

    // 3: fill both entries under stall, then drain in order
    cycle(0, 0, 1, 64'hA, 0);
    cycle(0, 0, 1, 64'hB, 0);
    check("t3_occ_full", 64'(occupancy), 64'd2);
    check("t3_in_ready_low", 64'(in_ready), 64'd0);
    cycle(0, 0, 1, 64'hEE, 0);
    check("t3_hold_head", out_data, 64'hA);
    cycle(0, 0, 0, '0, 1);
    check("t3_second", out_data, 64'hB);
    cycle(0, 0, 0, '0, 1);
    check("t3_drained", 64'(out_valid), 64'd0);

    // 4: flush while full with a concurrent input
    cycle(0, 0, 1, 64'hA, 0);
    cycle(0, 0, 1, 64'hB, 0);
    cycle(0, 1, 1, 64'hC, 0);
    check("t4_flush_valid", 64'(out_valid), 64'd0);
    check("t4_flush_occ", 64'(occupancy), 64'd0);
    check("t4_flush_ready", 64'(in_ready), 64'd1);
    cycle(0, 0, 0, '0, 1);
    check("t4_no_c", out_data, BUBBLE);

    // 5: reset while holding one entry and stalled
    cycle(0, 0, 1, 64'h55, 0);
    cycle(1, 0, 1, 64'h66, 0);
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_data", out_data, BUBBLE);
    check("t5_rst_occ", 64'(occupancy), 64'd0);
    cycle(0, 0, 0, '0, 0);

`ifdef PIPEREG_PERF_EN
    // 6: stall counter saturates and survives flush
    cycle(0, 0, 1, 64'h77, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, '0, 0);
    check("t6_stall_sat", 64'(stall_cnt), 64'hF);
    cycle(0, 1, 0, '0, 0);
    check("t6_stall_after_flush", 64'(stall_cnt), 64'hF);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 2) != 0), {$urandom, $urandom},
            ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
